wb_arbiter: RTL

//   Write-side master for the CPU register file: merges fixed-latency pipeline writebacks with

---
 rtl/wb_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Write-side master for the CPU register file. It merges two sources of
//   writes onto the single register-file write port:
//     * fixed-latency pipeline writebacks, which never wait and always win;
//     * long-latency (mul/div) results, buffered in a small in-order FIFO and
//       drained whenever the pipeline leaves the write port free.
//   It also keeps a pending-register scoreboard. Decode uses it to stall on
//   operands or destinations whose long-latency result is still outstanding.
//
// Ports
//   clk, rst                           clock (rising edge), async active-high reset
//   pipe_wen/pipe_rd/pipe_data         pipeline writeback (rd 0 = no write)
//   lu_issue/lu_issue_rd               long op issued: marks destination pending
//   lu_valid/lu_ready/lu_rd/lu_data    long result handshake (rd 0 = discarded)
//   dec_rs1/dec_rs2/dec_rd             decode register numbers
//   hazard                             decode must stall (combinational)
//   rf_wen/rf_rd/rf_wdata              registered register-file write port
//   pending                            scoreboard, bit n = x<n> awaiting result
//   fifo_count                         long-result FIFO occupancy
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_wen,
  input  logic [4:0]                 pipe_rd,
  input  logic [XLEN-1:0]            pipe_data,
  input  logic                       lu_issue,
  input  logic [4:0]                 lu_issue_rd,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [4:0]                 lu_rd,
  input  logic [XLEN-1:0]            lu_data,
  input  logic [4:0]                 dec_rs1,
  input  logic [4:0]                 dec_rs2,
  input  logic [4:0]                 dec_rd,
  output logic                       hazard,
  output logic                       rf_wen,
  output logic [4:0]                 rf_rd,
  output logic [XLEN-1:0]            rf_wdata,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // FIFO storage and control
  logic [XLEN-1:0]  mem_data_r [DEPTH];
  logic [4:0]       mem_rd_r   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Write port and scoreboard state
  logic             rf_wen_r;
  logic [4:0]       rf_rd_r;
  logic [XLEN-1:0]  rf_wdata_r;
  logic [31:0]      pending_r;

  // Per-cycle decisions
  logic             pipe_win_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [4:0]       head_rd_s;
  logic [XLEN-1:0]  head_data_s;
  logic [31:0]      set_mask_s;
  logic [31:0]      clr_mask_s;
  logic [31:0]      pending_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;

  // No same-cycle pop credit: ready depends only on the registered count.
  assign lu_ready    = ~rst & (count_r < CNT_W'(DEPTH));
  assign accept_s    = lu_valid & lu_ready;
  // Results for x0 are consumed from the unit but never stored.
  assign push_s      = accept_s & (lu_rd != 5'd0);
  assign pipe_win_s  = pipe_wen & (pipe_rd != 5'd0);
  // The pop sees only the registered count, so a push into an empty FIFO
  // cannot be forwarded to the write port in the same cycle.
  assign pop_s       = ~pipe_win_s & (count_r != {CNT_W{1'b0}});
  assign head_rd_s   = mem_rd_r[rd_ptr_r];
  assign head_data_s = mem_data_r[rd_ptr_r];

  assign hazard = ((dec_rs1 != 5'd0) & pending_r[dec_rs1]) |
                  ((dec_rs2 != 5'd0) & pending_r[dec_rs2]) |
                  ((dec_rd  != 5'd0) & pending_r[dec_rd]);

  assign rf_wen     = rf_wen_r;
  assign rf_rd      = rf_rd_r;
  assign rf_wdata   = rf_wdata_r;
  assign pending    = pending_r;
  assign fifo_count = count_r;

  // Scoreboard masks: set on issue, clear on the pop that writes the register.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (lu_issue && (lu_issue_rd != 5'd0)) begin
      set_mask_s[lu_issue_rd] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (pop_s) begin
      clr_mask_s[head_rd_s] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
    // Set is applied after clear so a re-issue on the popping edge wins.
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  end

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO payload storage; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= lu_data;
      mem_rd_r[wr_ptr_r]   <= lu_rd;
    end
  end

  // FIFO pointers, occupancy and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      pending_r <= 32'd0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r   <= count_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Register-file write port arbitration: pipeline first, then FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen_r   <= 1'b0;
      rf_rd_r    <= 5'd0;
      rf_wdata_r <= {XLEN{1'b0}};
    end else if (pipe_win_s) begin
      rf_wen_r   <= 1'b1;
      rf_rd_r    <= pipe_rd;
      rf_wdata_r <= pipe_data;
    end else if (pop_s) begin
      rf_wen_r   <= 1'b1;
      rf_rd_r    <= head_rd_s;
      rf_wdata_r <= head_data_s;
    end else begin
      // Address and data hold; only the enable drops.
      rf_wen_r   <= 1'b0;
    end
  end

endmodule
